// File: rtl/psa_arb.sv
// -----------------------------------------------------------------------------
// psa_arb -- two-requester round-robin arbiter in front of a shared 16-bit
// (4 x 4-bit) partitioned adder, with a single-entry registered response.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   r0_valid, r1_valid    requester i has an add pending
//   r0_ready, r1_ready    requester i's operation is accepted this cycle
//   r0_a, r0_b, r1_a, r1_b  16-bit operands per requester
//   psa_a, psa_b          operands presented to the shared adder
//   psa_sum, psa_err      combinational sum / OR of nibble overflows from adder
//   rsp_valid, rsp_ready  response handshake
//   rsp_id                requester index owning the response
//   rsp_sum, rsp_err      registered sum and overflow flag
//   err_clr, err_sticky   per-requester sticky overflow clear / status
//
// Build option
//   PSA_ARB_STICKY_ERR_EN  when defined, err_sticky records overflows per
//                          requester; otherwise err_sticky is 2'b00 and
//                          err_clr is ignored.
// -----------------------------------------------------------------------------
module psa_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [15:0] r0_a,
  input  logic [15:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [15:0] r1_a,
  input  logic [15:0] r1_b,
  output logic [15:0] psa_a,
  output logic [15:0] psa_b,
  input  logic [15:0] psa_sum,
  input  logic        psa_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_err,
  input  logic [1:0]  err_clr,
  output logic [1:0]  err_sticky
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   rr_ptr;
  logic   any_valid;
  logic   gnt_id;
  logic   can_accept;
  logic   accept;

  // Grant: a lone valid requester wins; a tie goes to rr_ptr.
  always_comb begin
    any_valid = r0_valid || r1_valid;
    gnt_id    = 1'b0;
    if (r0_valid && r1_valid) gnt_id = rr_ptr;
    else if (r1_valid)        gnt_id = 1'b1;
  end

  // rst_n gates acceptance so no requester sees ready while reset is held.
  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign accept     = any_valid && can_accept && rst_n;
  assign r0_ready   = accept && (gnt_id == 1'b0);
  assign r1_ready   = accept && (gnt_id == 1'b1);

  always_comb begin
    psa_a = '0;
    psa_b = '0;
    if (any_valid) begin
      psa_a = gnt_id ? r1_a : r0_a;
      psa_b = gnt_id ? r1_b : r0_b;
    end
  end

  // Response buffer FSM: accept always (re)fills; otherwise a drain empties.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign rsp_valid = (state_q == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_sum <= '0;
      rsp_err <= 1'b0;
      rsp_id  <= 1'b0;
      rr_ptr  <= 1'b0;
    end else if (accept) begin
      rsp_sum <= psa_sum;
      rsp_err <= psa_err;
      rsp_id  <= gnt_id;
      rr_ptr  <= ~gnt_id;
    end
  end

`ifdef PSA_ARB_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        // Set has priority over a same-cycle clear.
        if (accept && (gnt_id == i[0]) && psa_err) err_sticky[i] <= 1'b1;
        else if (err_clr[i])                      err_sticky[i] <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = ^err_clr;
  assign err_sticky     = '0;
`endif

  ready_onehot: assert property (@(posedge clk) !(r0_ready && r1_ready));

endmodule

// File: doc/psa_arb.md
PSA_ARB -- requirements
Module: psa_arb

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits, 2 requesters.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 r0_valid / r1_valid  input  1 each  requester i has an add operation pending.
REQ-005 r0_ready / r1_ready  output  1 each  requester i's operation accepted this cycle.
REQ-006 r0_a, r0_b / r1_a, r1_b  input  16 each  requester i operands.
REQ-007 psa_a, psa_b  output  16 each  operands driven to the shared 4x4-bit partitioned adder.
REQ-008 psa_sum  input  16  partitioned sum returned by the shared adder (combinational).
REQ-009 psa_err  input  1  OR of the four nibble overflow flags from the shared adder.
REQ-010 rsp_valid  output  1  response register holds a result.
REQ-011 rsp_ready  input  1  consumer takes the response this cycle.
REQ-012 rsp_id  output  1  requester index owning the response.
REQ-013 rsp_sum  output  16  registered sum; rsp_err  output  1  registered overflow flag.
REQ-014 err_clr  input  2  per-requester sticky-error clear; err_sticky  output  2  per-requester sticky error.

Function
REQ-015 Response buffer SHALL be one entry, states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 can_accept SHALL be 1 when EMPTY, or when FULL and rsp_ready=1 (same-cycle drain and refill).
REQ-017 Grant SHALL be combinational: one valid requester wins; both valid, the requester indicated by rr_ptr wins.
REQ-018 ri_ready SHALL be 1 only when requester i is granted and can_accept=1; at most one ready per cycle.
REQ-019 psa_a/psa_b SHALL carry the granted requester's operands; 0x0000 when none valid.
REQ-020 On an accepting edge: rsp_sum<=psa_sum, rsp_err<=psa_err, rsp_id<=granted index, state->FULL.
REQ-021 Latency SHALL be exactly 1 cycle: rsp_valid high the cycle after ri_valid&&ri_ready.
REQ-022 FULL with rsp_ready=1 and no accept SHALL go to EMPTY; FULL with rsp_ready=0 SHALL hold all rsp_* stable.
REQ-023 rr_ptr SHALL point to the non-accepted requester after each accept; unchanged when no accept.
REQ-024 Requesters SHALL hold valid and operands stable until ready; psa_arb does not buffer requests.
REQ-025 rsp_err SHALL be 1 if any nibble of the granted operation overflowed; rsp_sum carries the wrapped nibble sums.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force EMPTY, rsp_sum=0x0000, rsp_err=0, rsp_id=0, rr_ptr=0 (requester 0 preferred), err_sticky=2'b00.
REQ-027 During reset both ri_ready SHALL be 0; a pending response is discarded, never delivered.

Configuration
REQ-028 Macro PSA_ARB_STICKY_ERR_EN SHALL compile in the sticky-error logic.
REQ-029 Defined: err_sticky[i] sets on accept of requester i with psa_err=1, clears on err_clr[i]=1; set wins if both same cycle.
REQ-030 Undefined: err_sticky SHALL be constant 2'b00 and err_clr ignored; all other behaviour identical.

Verification
REQ-031 r0 a=0x1234 b=0x1111, rsp_ready=1 -> r0_ready=1 same cycle; next cycle rsp_valid=1, rsp_sum=0x2345, rsp_err=0, rsp_id=0.
REQ-032 r1 a=0x7000 b=0x1000 -> rsp_sum=0x8000, rsp_err=1, rsp_id=1; with macro err_sticky=2'b10 until err_clr[1] pulsed.
REQ-033 After reset both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 on consecutive cycles.
REQ-034 rsp_ready=0 for 5 cycles with rsp_valid=1 -> both ready=0, rsp_* unchanged; rsp_ready=1 -> drain and next accept same cycle.
REQ-035 rsp_valid=1 then rst_n=0 for one edge -> rsp_valid=0, rsp_sum=0x0000, rr_ptr=0; first post-reset grant goes to r0.
REQ-036 With macro: err_clr[0]=1 on same edge as r0 overflow accept -> err_sticky[0]=1.
